// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and default opcode width for the
// EX-stage ALU with iterative multiply/divide.
package alu_pkg;

  localparam int OP_W_DEF = 4;

  localparam int unsigned OP_ADDU = 0;
  localparam int unsigned OP_ADDS = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_SLTU = 4;
  localparam int unsigned OP_SUB  = 5;
  localparam int unsigned OP_SLTS = 6;
  localparam int unsigned OP_MUL  = 7;
  localparam int unsigned OP_DIVU = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_ITER  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one bit per step. acc holds {high/remainder, low/quotient}.
module mdu_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    // Remainder stays below the divisor, so bit WIDTH is a pure borrow flag.
    div_diff  = div_shift - {1'b0, opnd_q};
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (start) begin
      acc_d  = {{WIDTH{1'b0}}, a};
      opnd_d = b;
      div_d  = is_div;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      if (!div_q) begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign res_lo = acc_q[WIDTH-1:0];
  assign res_hi = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with valid/ready handshake, single-cycle ops and an
// iterative MUL/DIVU unit; every result and flag output is a register.
//
//   state    | meaning
//   ST_IDLE  | waiting for an operation
//   ST_EXEC1 | single-cycle op (or DIVU by zero) loads result next edge
//   ST_ITER  | mdu_iter stepping, one bit per cycle
//   ST_DONE  | iteration finished, result loads next edge
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             ovf,
  output logic             dz
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_q, result_d, result_hi_q, result_hi_d;
  logic              zero_q, zero_d, lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic              ovf_q, ovf_d, dz_q, dz_d;

  logic              accept, iter_start, load;
  logic              mdu_last;
  logic [WIDTH-1:0]  mdu_lo, mdu_hi;
  logic [WIDTH-1:0]  sum, diff, res_n, hi_n;
  logic              ovf_n, dz_n, legal_n;

  assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && ((op == OP_W'(OP_MUL)) ||
                                 ((op == OP_W'(OP_DIVU)) && (y != '0)));

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .step   (state_q == ST_ITER),
    .is_div (op == OP_W'(OP_DIVU)),
    .a      (x),
    .b      (y),
    .last   (mdu_last),
    .res_lo (mdu_lo),
    .res_hi (mdu_hi)
  );

  always_comb begin
    sum     = x_q + y_q;
    diff    = x_q - y_q;
    res_n   = '0;
    hi_n    = '0;
    ovf_n   = 1'b0;
    dz_n    = 1'b0;
    legal_n = 1'b1;
    case (op_q)
      OP_W'(OP_ADDU): res_n = sum;
      OP_W'(OP_ADDS): begin
        res_n = sum;
        ovf_n = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (sum[WIDTH-1] != x_q[WIDTH-1]);
      end
      OP_W'(OP_AND):  res_n = x_q & y_q;
      OP_W'(OP_OR):   res_n = x_q | y_q;
      OP_W'(OP_SLTU): res_n = {{(WIDTH-1){1'b0}}, x_q < y_q};
      OP_W'(OP_SUB): begin
        res_n = diff;
        ovf_n = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (diff[WIDTH-1] != x_q[WIDTH-1]);
      end
      OP_W'(OP_SLTS): res_n = {{(WIDTH-1){1'b0}}, $signed(x_q) < $signed(y_q)};
      OP_W'(OP_MUL): begin
        res_n = mdu_lo;
        hi_n  = mdu_hi;
      end
      OP_W'(OP_DIVU): begin
        if (y_q == '0) begin
          res_n = '1;
          hi_n  = x_q;
          dz_n  = 1'b1;
        end else begin
          res_n = mdu_lo;
          hi_n  = mdu_hi;
        end
      end
      default: legal_n = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    load        = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d     = x;
          y_d     = y;
          op_d    = op;
          state_d = iter_start ? ST_ITER : ST_EXEC1;
        end
      end
      ST_ITER:  if (mdu_last) state_d = ST_DONE;
      ST_EXEC1, ST_DONE: begin
        load    = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    // Unassigned opcodes report a zero result with every flag cleared.
    if (load) begin
      out_valid_d = 1'b1;
      result_d    = res_n;
      result_hi_d = hi_n;
      zero_d      = legal_n && (res_n == '0);
      lt_d        = legal_n && (x_q < y_q);
      eq_d        = legal_n && (x_q == y_q);
      gt_d        = legal_n && (x_q > y_q);
      ovf_d       = ovf_n;
      dz_d        = dz_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at WIDTH=16: single-cycle op table, back-to-back,
// MUL/DIVU latency, divide by zero, backpressure and reset mid-operation.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_i;
  logic [15:0] x_i, y_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result, result_hi;
  logic        zero, lt, eq, gt, ovf, dz;
  logic [5:0]  flags;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] res;
    logic [5:0]  fl;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  assign flags = {zero, lt, eq, gt, ovf, dz};

  alu_mdu #(.WIDTH(16), .OP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_i),
    .x         (x_i),
    .y         (y_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt),
    .ovf       (ovf),
    .dz        (dz)
  );

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic drive_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    op_i = o; x_i = a; y_i = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_i = 16'hDEAD; y_i = 16'hBEEF; op_i = 4'h5;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 60);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_i = '0; x_i = '0; y_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vec_cnt++;
    if ({out_valid, result, result_hi, flags, in_ready} !== {1'b0, 16'h0, 16'h0, 6'h0, 1'b1}) begin
      err_cnt++;
      $display("FAIL reset: got v=%b r=%h hi=%h fl=%b rdy=%b, want v=0 r=0 hi=0 fl=0 rdy=1",
               out_valid, result, result_hi, flags, in_ready);
    end
  endtask

  task automatic test_single_cycle;
    int lat;
    tbl = '{
      '{4'd0,  16'hFFFF, 16'h0002, 16'h0001, 6'b000100},
      '{4'd1,  16'h7FFF, 16'h0001, 16'h8000, 6'b000110},
      '{4'd1,  16'h8000, 16'hFFFF, 16'h7FFF, 6'b010010},
      '{4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 6'b000100},
      '{4'd3,  16'h0000, 16'h0000, 16'h0000, 6'b101000},
      '{4'd4,  16'h0001, 16'h0002, 16'h0001, 6'b010000},
      '{4'd5,  16'h0005, 16'h0005, 16'h0000, 6'b101000},
      '{4'd5,  16'h8000, 16'h0001, 16'h7FFF, 6'b000110},
      '{4'd6,  16'hFFFF, 16'h0001, 16'h0001, 6'b000100},
      '{4'd6,  16'h0001, 16'hFFFF, 16'h0000, 6'b110000},
      '{4'd9,  16'h0001, 16'h0002, 16'h0000, 6'b000000},
      '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 6'b000000}
    };
    for (int i = 0; i < 12; i++) begin
      drive_op(tbl[i].op, tbl[i].x, tbl[i].y);
      wait_out(lat);
      vec_cnt++;
      if (lat !== 1) begin
        err_cnt++;
        $display("FAIL single_lat[%0d]: got %0d cycles, want 1", i, lat);
      end
      vec_cnt++;
      if ({result, result_hi, flags} !== {tbl[i].res, 16'h0, tbl[i].fl}) begin
        err_cnt++;
        $display("FAIL single_out[%0d] op=%0d: got r=%h hi=%h fl=%b, want r=%h hi=0000 fl=%b",
                 i, tbl[i].op, result, result_hi, flags, tbl[i].res, tbl[i].fl);
      end
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL pop: out_valid got %b after consume, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    drive_op(4'd5, 16'h0005, 16'h0005);
    op_i = 4'd6; x_i = 16'hFFFF; y_i = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({out_valid, result, flags, in_ready} !== {1'b1, 16'h0000, 6'b101000, 1'b1}) begin
      err_cnt++;
      $display("FAIL b2b_sub: got v=%b r=%h fl=%b rdy=%b, want v=1 r=0000 fl=101000 rdy=1",
               out_valid, result, flags, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; x_i = 16'h0; y_i = 16'h0;
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b00) begin
      err_cnt++;
      $display("FAIL b2b_accept: got v=%b rdy=%b, want v=0 rdy=0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if ({out_valid, result, flags} !== {1'b1, 16'h0001, 6'b000100}) begin
      err_cnt++;
      $display("FAIL b2b_slts: got v=%b r=%h fl=%b, want v=1 r=0001 fl=000100",
               out_valid, result, flags);
    end
  endtask

  task automatic run_iter(input string name, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic [15:0] eh,
                          input logic [5:0] ef);
    int busy_bad = 0;
    drive_op(o, a, b);
    if (in_ready || out_valid) busy_bad++;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (in_ready || out_valid) busy_bad++;
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (busy_bad !== 0 || out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_timing: got %0d busy violations, out_valid=%b at N+17, want 0 and 1",
               name, busy_bad, out_valid);
    end
    vec_cnt++;
    if ({result, result_hi, flags} !== {er, eh, ef}) begin
      err_cnt++;
      $display("FAIL %s_out: got r=%h hi=%h fl=%b, want r=%h hi=%h fl=%b",
               name, result, result_hi, flags, er, eh, ef);
    end
  endtask

  task automatic test_mul_div;
    int lat;
    run_iter("mul", 4'd7, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 6'b000100);
    run_iter("mul_max", 4'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 6'b001000);
    run_iter("divu", 4'd8, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 6'b000100);
    run_iter("divu_small", 4'd8, 16'h0003, 16'h0009, 16'h0000, 16'h0003, 6'b110000);
    drive_op(4'd8, 16'h00AB, 16'h0000);
    wait_out(lat);
    vec_cnt++;
    if (lat !== 1) begin
      err_cnt++;
      $display("FAIL dz_lat: got %0d cycles, want 1", lat);
    end
    vec_cnt++;
    if ({result, result_hi, flags} !== {16'hFFFF, 16'h00AB, 6'b000101}) begin
      err_cnt++;
      $display("FAIL dz_out: got r=%h hi=%h fl=%b, want r=ffff hi=00ab fl=000101",
               result, result_hi, flags);
    end
  endtask

  task automatic test_backpressure;
    int hold_bad = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_op(4'd0, 16'h0003, 16'h0004);
    op_i = 4'd3; x_i = 16'h00F0; y_i = 16'h000F; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 16'h0007 || flags !== 6'b010000 || in_ready !== 1'b0)
        hold_bad++;
    end
    vec_cnt++;
    if (hold_bad !== 0) begin
      err_cnt++;
      $display("FAIL bp_hold: got %0d bad cycles (last v=%b r=%h rdy=%b), want 0",
               hold_bad, out_valid, result, in_ready);
    end
    out_ready = 1'b1;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_ready: got in_ready=%b with out_ready=1, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; x_i = 16'h0; y_i = 16'h0;
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b00) begin
      err_cnt++;
      $display("FAIL bp_pop_accept: got v=%b rdy=%b, want v=0 rdy=0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if ({out_valid, result, flags} !== {1'b1, 16'h00FF, 6'b000100}) begin
      err_cnt++;
      $display("FAIL bp_second: got v=%b r=%h fl=%b, want v=1 r=00ff fl=000100",
               out_valid, result, flags);
    end
  endtask

  task automatic test_reset_mid_op;
    int stale = 0;
    drive_op(4'd7, 16'h1234, 16'h0100);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({out_valid, result, result_hi, flags, in_ready} !== {1'b0, 16'h0, 16'h0, 6'h0, 1'b1}) begin
      err_cnt++;
      $display("FAIL rst_mid: got v=%b r=%h hi=%h fl=%b rdy=%b, want v=0 r=0 hi=0 fl=0 rdy=1",
               out_valid, result, result_hi, flags, in_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
    end
    vec_cnt++;
    if (stale !== 0) begin
      err_cnt++;
      $display("FAIL rst_stale: got %0d cycles with a result or busy after reset, want 0", stale);
    end
  endtask

  initial begin
    test_reset;
    test_single_cycle;
    test_back_to_back;
    test_mul_div;
    test_backpressure;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
